// File: rtl/nano_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : nano_uart_loader
// Description : Serial program loader for the Nano CPU program memory.
//               Receives 8N1 UART bytes on rx_i. Each correctly framed byte
//               is written to the next program-memory address. The CPU is
//               held in reset while load_en is high.
// Ports       : clk        - system clock
//               rst_n      - synchronous active-low reset
//               rx_i       - asynchronous UART input, idles high
//               load_en    - load mode (high = loading), synchronous to clk
//               mem_we     - one-cycle program-memory write strobe
//               mem_addr   - program-memory write address
//               mem_wdata  - program-memory write data
//               busy       - receiver is inside a frame (FSM not idle)
//               done       - sticky, last address has been written
//               frame_err  - sticky, a frame arrived with a bad stop bit
//               cpu_rst_n  - registered active-low reset to the CPU core
// Revision    : 1.0 - initial release
// ============================================================================
module nano_uart_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    input  logic              load_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              cpu_rst_n
);

    localparam int               c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_last_idx  = 3'(DATA_W - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_write = 3'd4;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic               r_load_en_d;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [DATA_W-1:0]  r_shift;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_done;
    logic               r_frame_err;
    logic               r_cpu_rst_n;
    logic               w_load_rise;
    logic               w_done_block;
    logic               w_cnt_half;
    logic               w_cnt_bit;

    assign w_load_rise  = load_en & ~r_load_en_d;
    // A fresh load session clears done in the same edge, so it must not
    // block a start bit seen in that cycle.
    assign w_done_block = r_done & ~w_load_rise;
    assign w_cnt_half   = (r_cnt == c_half_last);
    assign w_cnt_bit    = (r_cnt == c_bit_last);

    // Two-flop synchronizer; resets to the line idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_en_d <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_load_en_d <= load_en;
            r_cpu_rst_n <= ~load_en;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; leaving load mode aborts any frame.
    always_comb begin
        w_state_next = r_state;
        if (!load_en) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_done_block && !r_rx_s) begin
                        w_state_next = c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_cnt_half) begin
                        w_state_next = r_rx_s ? c_st_idle : c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_cnt_bit && (r_bit_idx == c_last_idx)) begin
                        w_state_next = c_st_stop;
                    end
                end
                c_st_stop: begin
                    // Leaving at mid-stop-bit lets a directly following
                    // start bit be captured.
                    if (w_cnt_bit) begin
                        w_state_next = r_rx_s ? c_st_write : c_st_idle;
                    end
                end
                c_st_write: w_state_next = c_st_idle;
                default:    w_state_next = c_st_idle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        mem_we = (r_state == c_st_write) && load_en;
        busy   = (r_state != c_st_idle);
    end

    // Bit timing and data capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else if (!load_en) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                c_st_start: begin
                    if (w_cnt_half) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_data: begin
                    if (w_cnt_bit) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_shift   <= {r_rx_s, r_shift[DATA_W-1:1]};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_stop: begin
                    r_cnt <= w_cnt_bit ? '0 : r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Address and sticky status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (w_load_rise) begin
            r_addr      <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (load_en) begin
            if ((r_state == c_st_stop) && w_cnt_bit && !r_rx_s) begin
                r_frame_err <= 1'b1;
            end
            if (r_state == c_st_write) begin
                if (&r_addr) begin
                    r_done <= 1'b1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_shift;
    assign done      = r_done;
    assign frame_err = r_frame_err;
    assign cpu_rst_n = r_cpu_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_nano_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_nano_uart_loader
// Description : Self-checking bench for nano_uart_loader. Vector table of
//               frames with expected results, hand-written sequences for
//               glitch, mode exit and full load, and a randomized frame
//               stream checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nano_uart_loader;

    localparam int c_clks = 16;
    localparam int c_half = c_clks / 2;
    localparam int c_aw   = 5;
    // Drive of the start-bit edge to mem_we: 2 sync cycles, then H + 9 bits + 1.
    localparam int c_lat  = 2 + c_half + 9 * c_clks + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_i;
    logic            load_en;
    logic            mem_we;
    logic [c_aw-1:0] mem_addr;
    logic [7:0]      mem_wdata;
    logic            busy;
    logic            done;
    logic            frame_err;
    logic            cpu_rst_n;

    nano_uart_loader #(
        .CLKS_PER_BIT (c_clks),
        .ADDR_W       (c_aw),
        .DATA_W       (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx_i),
        .load_en   (load_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int last_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [c_aw-1:0] addr;
        logic [7:0]      data;
        int              cyc;
    } wr_t;

    wr_t wr_q[$];
    wr_t exp_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            wr_q.push_back('{addr: mem_addr, data: mem_wdata, cyc: cyc});
        end
    end

    typedef struct {
        logic [7:0]      data;
        logic            stop;
        logic            exp_we;
        logic [c_aw-1:0] exp_waddr;
        logic [c_aw-1:0] exp_addr;
        logic            exp_err;
    } vec_t;

    vec_t tbl[6];

    // Reference model state
    int m_addr;
    bit m_done;
    bit m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is positioned just after a falling edge; returns likewise.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
        rx_i = 1'b0;
        last_start = cyc;
        repeat (c_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (c_clks) @(negedge clk);
        end
        rx_i = stop;
        repeat (c_clks) @(negedge clk);
        rx_i = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic restart_load();
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop, input int start);
        if (!m_done) begin
            if (!stop) begin
                m_err = 1'b1;
            end else begin
                exp_q.push_back('{addr: c_aw'(m_addr), data: d, cyc: start + c_lat});
                if (m_addr == (1 << c_aw) - 1) m_done = 1'b1;
                else m_addr++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb;
        bit  seen_busy;
        int  starts[33];
        wr_t w;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 5'd0, 5'd1, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 5'd0, 5'd1, 1'b1};
        tbl[2] = '{8'h11, 1'b1, 1'b1, 5'd1, 5'd2, 1'b1};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 5'd2, 5'd3, 1'b1};
        tbl[4] = '{8'h80, 1'b0, 1'b0, 5'd0, 5'd3, 1'b1};
        tbl[5] = '{8'h01, 1'b1, 1'b1, 5'd3, 5'd4, 1'b1};

        // ---------------- reset ----------------
        rst_n   = 1'b0;
        load_en = 1'b1;
        rx_i    = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs",
              32'({mem_we, mem_addr, mem_wdata, busy, done, frame_err, cpu_rst_n}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        // ---------------- glitch rejection ----------------
        seen_busy = 1'b0;
        rx_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == c_clks / 4 - 1) rx_i = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        check("glitch_busy_pulse", 32'(seen_busy), 32'd1);
        check("glitch_busy_idle", 32'(busy), 32'd0);
        check("glitch_no_write", 32'(wr_q.size()), 32'd0);
        check("glitch_no_err", 32'(frame_err), 32'd0);
        check("glitch_addr", 32'(mem_addr), 32'd0);

        // ---------------- vector table ----------------
        foreach (tbl[k]) begin
            nb = wr_q.size();
            send_frame(tbl[k].data, tbl[k].stop, 2 * c_clks);
            check("tbl_we_count", 32'(wr_q.size() - nb), 32'(tbl[k].exp_we));
            if (tbl[k].exp_we && wr_q.size() > nb) begin
                w = wr_q[wr_q.size() - 1];
                check("tbl_waddr", 32'(w.addr), 32'(tbl[k].exp_waddr));
                check("tbl_wdata", 32'(w.data), 32'(tbl[k].data));
                check("tbl_latency", 32'(w.cyc), 32'(last_start + c_lat));
            end
            check("tbl_mem_addr", 32'(mem_addr), 32'(tbl[k].exp_addr));
            check("tbl_frame_err", 32'(frame_err), 32'(tbl[k].exp_err));
        end
        wr_q.delete();

        // ---------------- mode exit mid-frame ----------------
        fork
            send_frame(8'hC3, 1'b1, 2 * c_clks);
            begin
                repeat (4 * c_clks) @(negedge clk);
                load_en = 1'b0;
                @(negedge clk);
                check("exit_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
                check("exit_busy", 32'(busy), 32'd0);
            end
        join
        check("exit_no_write", 32'(wr_q.size()), 32'd0);
        check("exit_addr_kept", 32'(mem_addr), 32'd4);
        check("exit_err_kept", 32'(frame_err), 32'd1);
        load_en = 1'b1;
        @(negedge clk);
        check("reentry_clear", 32'({mem_addr, done, frame_err}), 32'd0);
        check("reentry_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        send_frame(8'h5A, 1'b1, 2);
        check("reentry_write_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) begin
            check("reentry_waddr", 32'(wr_q[0].addr), 32'd0);
            check("reentry_wdata", 32'(wr_q[0].data), 32'h5A);
        end
        check("reentry_next_addr", 32'(mem_addr), 32'd1);
        wr_q.delete();

        // ---------------- full load, back-to-back ----------------
        restart_load();
        for (int i = 0; i < 32; i++) begin
            send_frame(8'(i), 1'b1, 0);
            starts[i] = last_start;
        end
        check("full_write_count", 32'(wr_q.size()), 32'd32);
        for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
            check("full_waddr", 32'(wr_q[i].addr), 32'(i));
            check("full_wdata", 32'(wr_q[i].data), 32'(i));
            check("full_latency", 32'(wr_q[i].cyc), 32'(starts[i] + c_lat));
        end
        check("full_done", 32'(done), 32'd1);
        check("full_addr_held", 32'(mem_addr), 32'd31);
        send_frame(8'h20, 1'b1, 2 * c_clks);
        check("after_done_no_write", 32'(wr_q.size()), 32'd32);
        check("after_done_done", 32'(done), 32'd1);
        check("after_done_addr", 32'(mem_addr), 32'd31);
        wr_q.delete();

        // ---------------- randomized stream vs model ----------------
        restart_load();
        m_addr = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            logic       s;
            int         g;
            d = 8'($urandom);
            s = ($urandom_range(0, 5) != 0);
            g = s ? int'($urandom_range(0, 3)) : 2 * c_clks + int'($urandom_range(0, 5));
            send_frame(d, s, g);
            model_frame(d, s, last_start);
        end
        repeat (4) @(negedge clk);
        check("rand_write_count", 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check("rand_waddr", 32'(wr_q[i].addr), 32'(exp_q[i].addr));
            check("rand_wdata", 32'(wr_q[i].data), 32'(exp_q[i].data));
            check("rand_wcycle", 32'(wr_q[i].cyc), 32'(exp_q[i].cyc));
        end
        check("rand_mem_addr", 32'(mem_addr), 32'(m_addr));
        check("rand_done", 32'(done), 32'(m_done));
        check("rand_frame_err", 32'(frame_err), 32'(m_err));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nano_uart_loader.md
# nano_uart_loader

Serial program loader sitting directly upstream of the Nano CPU core's program memory. It receives 8N1 UART bytes on a dedicated input pin and writes them to consecutive program-memory addresses. While loading, it holds the CPU in reset; it releases the CPU when loading ends. It lets the chip be programmed through one `ui_in` bit without a parallel bus.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16 — clock cycles per UART bit; must be even and ≥ 4.
- `ADDR_W`, 5 — program-memory address width (2^ADDR_W words).
- `DATA_W`, 8 — word width; fixed at 8 (one UART byte per word).

Ports:
- `clk`  in  1  — system clock.
- `rst_n`  in  1  — synchronous, active-low reset.
- `rx_i`  in  1  — UART serial input; asynchronous; idles high.
- `load_en`  in  1  — load mode; synchronous to `clk`; high = loading.
- `mem_we`  out  1  — one-cycle program-memory write strobe.
- `mem_addr`  out  ADDR_W  — write address.
- `mem_wdata`  out  8  — write data.
- `busy`  out  1  — high while a frame is being received (FSM not in IDLE).
- `done`  out  1  — sticky; high once the last address has been written.
- `frame_err`  out  1  — sticky; high after any frame with a bad stop bit.
- `cpu_rst_n`  out  1  — reset to the CPU core; registered.

## Operation
- **rx synchronizer:** `rx_i` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP, WRITE. `cnt` is the bit-period counter; `bit_idx` runs 0..7.
- **IDLE:** if `load_en` = 1, `done` = 0 and `rx_s` = 0, go to START with `cnt` = 0.
- **START:**
  - At `cnt` = CLKS_PER_BIT/2 − 1, sample `rx_s`.
  - If 0, go to DATA with `cnt` = 0 and `bit_idx` = 0.
  - If 1, treat it as a glitch and return to IDLE.
- **DATA:**
  - At `cnt` = CLKS_PER_BIT − 1, shift `rx_s` into the shift register LSB-first and set `cnt` = 0.
  - After `bit_idx` = 7 is sampled, go to STOP.
- **STOP:** at `cnt` = CLKS_PER_BIT − 1, sample `rx_s`.
  - If 1, go to WRITE.
  - If 0, set `frame_err`, discard the byte and return to IDLE. The address does not advance.
- **WRITE (one cycle):**
  - `mem_we` = 1, `mem_wdata` = shift register, `mem_addr` = current address.
  - Next cycle: if the address was 2^ADDR_W − 1, set `done` and hold the address. Otherwise increment the address.
  - Return to IDLE.
- **After `done`:** further frames are ignored and the FSM stays in IDLE until the flags are cleared.
- **Rising edge of `load_en`** (detected against a registered copy): clear `mem_addr`, `done` and `frame_err` to 0.
- **`load_en` = 0:**
  - The FSM is forced to IDLE and `mem_we` = 0.
  - Any in-flight frame is aborted and the address is kept.
  - `done` and `frame_err` keep their values.
- **`cpu_rst_n`:** next value = `rst_n` & ~`load_en`.
- **Reset values:**
  - `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `frame_err`, `cpu_rst_n` all = 0.
  - FSM = IDLE; `cnt` = 0; `bit_idx` = 0.

## Timing
- **Sync latency:** a pin edge on `rx_i` appears on `rx_s` 2 cycles later.
- Let t be the first cycle in which IDLE sees `rx_s` = 0, and H = CLKS_PER_BIT/2.
  - Start bit confirmed at t+H.
  - Data bit k sampled at t+H+(k+1)·CLKS_PER_BIT.
  - Stop bit sampled at t+H+9·CLKS_PER_BIT.
  - `mem_we` high exactly in cycle t+H+9·CLKS_PER_BIT+1. With the default CLKS_PER_BIT = 16 this is t+153.
- **Address update:** `mem_addr` and `mem_wdata` are stable throughout the `mem_we` cycle. The address increment becomes visible the cycle after.
- **`busy`:** high from t+1 through the WRITE cycle inclusive.
- **Back-to-back frames:** IDLE is re-entered mid-stop-bit, so a start bit following immediately is captured. No inter-frame gap is required.
- **`cpu_rst_n`:** follows `load_en` with 1 cycle of latency.
- **`load_en` falling in the WRITE cycle:** `load_en` = 0 has priority; no write occurs and the address is unchanged.

## Test plan
- **Reset:** hold `rst_n` = 0 with `rx_i` = 1 and `load_en` = 1 → all outputs 0. Release → `cpu_rst_n` stays 0 and `busy` = 0.
- **Single byte:** `load_en` = 1, send 0xA5 → one `mem_we` pulse with addr 0 and data 0xA5, 153 cycles after `rx_s` falls. Then `mem_addr` = 1 and `frame_err` = 0.
- **Bad stop bit:** send 0x3C with stop bit = 0 → no `mem_we`, `frame_err` = 1, `mem_addr` unchanged. The next good byte 0x11 is written to the same address.
- **Glitch rejection:** a low pulse on `rx_i` of CLKS_PER_BIT/4 cycles → `busy` pulses, then returns to IDLE with no write and no `frame_err`.
- **Full load:** send 32 bytes back-to-back (values 0x00..0x1F) → addresses 0..31 written with matching data. `done` = 1 after the last write. A 33rd byte produces no `mem_we`.
- **Mode exit and re-entry:** drop `load_en` mid-frame → `mem_we` stays 0 and `cpu_rst_n` = 1 next cycle. Raise `load_en` again → `mem_addr`, `done` and `frame_err` are 0, and the next byte is written to address 0.
